// File: rtl/prores_entropy_pkg.sv
// Shared constants, state type and small helpers for the entropy bitstream packer.
package prores_entropy_pkg;

  localparam int OUT_W     = 32;
  localparam int CODE_W    = 24;
  localparam int LEN_W     = 6;
  localparam int FILL_W    = 7;
  localparam int DRAIN_THR = 39;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pk_state_e;

  // Overlong codewords are truncated to the widest legal codeword.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : len;
  endfunction

  function automatic logic [2:0] ceil_bytes(input logic [4:0] nbits);
    return 3'(({1'b0, nbits} + 6'd7) >> 3);
  endfunction

endpackage

// File: rtl/entropy_packer_out_reg.sv
// One-entry output holding register with valid/ready handshake (data, last, nbytes).
module entropy_packer_out_reg #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [OUT_W-1:0] i_data,
  input  logic             i_last,
  input  logic [2:0]       i_nbytes,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic [2:0]       o_nbytes,
  output logic             o_space
);

  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic             r_last;
  logic [2:0]       r_nbytes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_nbytes <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_data   <= i_data;
      r_last   <= i_last;
      r_nbytes <= i_nbytes;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_space  = !r_valid || i_ready;
  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_last   = r_last;
  assign o_nbytes = r_nbytes;

endmodule

// File: rtl/entropy_bitstream_packer.sv
// MSB-first packer of variable-length codewords into 32-bit words with slice flush.
// Optional PACKER_BIT_COUNT_EN adds the per-slice bit_count output.
module entropy_bitstream_packer #(
  parameter int OUT_W  = prores_entropy_pkg::OUT_W,
  parameter int CODE_W = prores_entropy_pkg::CODE_W,
  parameter int LEN_W  = prores_entropy_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [2:0]        out_nbytes,
  output logic              len_err
`ifdef PACKER_BIT_COUNT_EN
  ,
  output logic [31:0]       bit_count
`endif
);
  import prores_entropy_pkg::*;

  localparam int ACC_W = 2 * OUT_W;

  pk_state_e         r_state, w_state_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_m, w_code_ext;
  logic [FILL_W-1:0] r_fill, w_fill_m, w_add_len, w_shamt;
  logic [LEN_W-1:0]  w_len;
  logic [CODE_W-1:0] w_mask;
  logic              w_accept, w_pend, w_full, w_last, w_load, w_space;
  logic              r_len_err;
  logic [2:0]        w_nbytes;

  // Merge the incoming codeword below the current fill before deciding on an emit,
  // so a word completed by this accept is loaded in the same cycle.
  assign w_accept   = in_valid && in_ready;
  assign w_len      = clamp_len(in_len);
  assign w_mask     = ~({CODE_W{1'b1}} << w_len);
  assign w_add_len  = w_accept ? FILL_W'(w_len) : '0;
  assign w_code_ext = w_accept ? ACC_W'(in_code & w_mask) : '0;
  assign w_shamt    = FILL_W'(ACC_W) - r_fill - w_add_len;
  assign w_acc_m    = r_acc | (w_code_ext << w_shamt);
  assign w_fill_m   = r_fill + w_add_len;

  assign w_pend   = (r_state == DRAIN) || (w_accept && in_flush);
  assign w_full   = w_fill_m >= FILL_W'(OUT_W);
  assign w_last   = w_pend && (w_fill_m <= FILL_W'(OUT_W));
  assign w_load   = w_space && (w_full || w_pend);
  assign w_nbytes = w_full ? 3'd4 : ceil_bytes(w_fill_m[4:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_accept && in_flush && !(w_load && w_last)) w_state_nxt = DRAIN;
      DRAIN:   if (w_load && w_last) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    in_ready = (r_state == RUN) && (r_fill <= FILL_W'(DRAIN_THR));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_fill    <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_load && w_last) begin
        r_acc  <= '0;
        r_fill <= '0;
      end else if (w_load) begin
        r_acc  <= {w_acc_m[ACC_W-OUT_W-1:0], {OUT_W{1'b0}}};
        r_fill <= w_fill_m - FILL_W'(OUT_W);
      end else begin
        r_acc  <= w_acc_m;
        r_fill <= w_fill_m;
      end
      r_len_err <= r_len_err | (w_accept && (in_len > LEN_W'(CODE_W)));
    end
  end

  assign len_err = r_len_err;

  entropy_packer_out_reg #(.OUT_W(OUT_W)) u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_data   (w_acc_m[ACC_W-1:ACC_W-OUT_W]),
    .i_last   (w_last),
    .i_nbytes (w_nbytes),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_last   (out_last),
    .o_nbytes (out_nbytes),
    .o_space  (w_space)
  );

`ifdef PACKER_BIT_COUNT_EN
  logic [31:0] r_bit_count;
  logic [32:0] w_bc_sum;
  logic        w_take_last;

  // The count belongs to the slice until its final word leaves; an accept in that
  // same cycle already starts the next slice.
  assign w_take_last = out_valid && out_ready && out_last;
  assign w_bc_sum    = {1'b0, r_bit_count} + 33'(w_add_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_bit_count <= '0;
    else if (w_take_last) r_bit_count <= 32'(w_add_len);
    else if (w_accept)    r_bit_count <= w_bc_sum[32] ? '1 : w_bc_sum[31:0];
  end

  assign bit_count = r_bit_count;
`endif

endmodule

// File: doc/entropy_bitstream_packer.md
# entropy_bitstream_packer

Packs the variable-length codewords produced by the entropy coding stages (DC, AC run and AC level) into a contiguous MSB-first bitstream of 32-bit words. It sits directly downstream of the run/level codeword generators and upstream of the slice writer. On flush it closes a slice by zero-padding the final word and reporting how many of its bytes are valid.

## Interface
Parameters:
- OUT_W, 32: output word width in bits; fixed at 32.
- CODE_W, 24: maximum codeword width in bits.
- LEN_W, 6: width of the codeword length field.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword present
- in_ready  out  1  packer accepts a codeword this cycle
- in_code  in  24  codeword, right-aligned; bits at and above in_len are ignored
- in_len  in  6  codeword length, 0..24
- in_flush  in  1  qualified by in_valid; this codeword is the last of the slice
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer takes the word
- out_data  out  32  packed bits, first bit in bit 31
- out_last  out  1  final word of the slice
- out_nbytes  out  3  valid bytes in the word: 4 unless out_last; 0..4 when out_last
- len_err  out  1  sticky flag: an in_len greater than 24 was accepted
- bit_count  out  32  bits accepted in the current slice; present only with the configuration macro

## Operation
- 64-bit accumulator `acc` plus a fill count `fill` (0..63). New bits are appended immediately below the existing fill.
- Accept occurs when in_valid && in_ready.
  - The masked low in_len bits of in_code are appended and `fill` increases by in_len.
  - in_len = 0 is accepted with no effect on the data.
  - in_len in 25..63 is clamped to 24 and sets len_err. len_err stays set until reset.
- States:
  - RUN: in_ready = (fill <= 39). Going to DRAIN happens on an accept with in_flush.
  - DRAIN: in_ready = 0. Full words are emitted while fill >= 32. When fill < 32, the final word is emitted and the state goes to RUN.
- Emit: when fill >= 32 and the output register is empty or is being taken this cycle (!out_valid || out_ready):
  - load out_data = acc[63:32], then shift acc left by 32 and reduce fill by 32;
  - out_last = 0, out_nbytes = 4.
- Final word:
  - If fill > 0: the remaining bits are zero-padded on the right; out_nbytes = ceil(fill/8).
  - If the last full word leaves fill = 0: that full word carries out_last = 1 with out_nbytes = 4.
  - If the slice is empty: one all-zero word with out_last = 1 and out_nbytes = 0.
  - After the final word, acc and fill are cleared and bit_count is reset to 0.
- Accept and emit in the same cycle: fill_next = fill + len − 32. Bit order is preserved.
- out_data, out_last and out_nbytes stay stable while out_valid && !out_ready.
- No codeword bit is ever lost or duplicated under any out_ready pattern.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, out_nbytes 0, len_err 0, bit_count 0, acc 0, fill 0, state RUN.
- in_ready is 1 in the first cycle after reset deassertion.
- in_ready depends only on registered state; it has no combinational path from in_valid or out_ready.
- Latency: a codeword accepted in cycle N that completes a word produces out_valid in cycle N+1.
- Flush: with out_ready held high, the final word appears no later than N+2 after the flush accept.
- Sustained throughput is one codeword per cycle while the average length is ≤ 32 and out_ready is high.
- Reset asserted mid-slice discards all buffered bits immediately, with no partial output.

## Configuration
- PACKER_BIT_COUNT_EN defined:
  - bit_count exists;
  - it is incremented by the clamped length on every accept;
  - it saturates at 2^32−1;
  - it returns to 0 after the final word of each slice is taken.
- PACKER_BIT_COUNT_EN undefined: the bit_count port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `prores_entropy_pkg` holds:
  - CODE_W, LEN_W and OUT_W;
  - the drain threshold 39;
  - the state enum {RUN, DRAIN}.
- One sub-module, `entropy_packer_out_reg`: a one-entry output holding register with valid/ready handshake, carrying data, last and nbytes.

## Test plan
- Reset released -> out_valid 0, in_ready 1, len_err 0, bit_count 0.
- Codes 0xAB, 0xCD, 0xEF, 0x12, each with len 8 and out_ready high -> one word 0xABCDEF12, out_last 0, out_nbytes 4, valid in the cycle after the 4th accept.
- Code 0x5 with len 3 and in_flush -> 0xA0000000, out_last 1, out_nbytes 1; bit_count reads 3 before the word is taken and 0 after.
- out_ready low, continuous codes with len 24 and value 0xFFFFFF -> in_ready falls once fill > 39; out_data is held stable. Releasing out_ready yields all-ones words with no bit loss.
- Flush with len 0 on an empty slice -> a single word 0x00000000, out_last 1, out_nbytes 0.
- in_len 30 with code 0xFFFFFFF -> treated as 24 ones; len_err goes high and stays high until reset_n is asserted.
